// File: rtl/dmem_copy_engine.sv
// Memory-to-memory block mover for the 64 x 32-bit data memory: one read
// cycle then one write cycle per word, with a running checksum of the words copied.
`timescale 1ns/1ps

module dmem_copy_engine #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] checksum,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  // Handshake: start is a request pulse that is accepted only in IDLE; the
  // engine answers each accepted start with exactly one done pulse (err valid with it).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  state_t        state;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [AW:0]   cnt;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      cnt      <= '0;
      data_q   <= '0;
      checksum <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (start) begin
            src_ptr  <= src_addr;
            dst_ptr  <= dst_addr;
            cnt      <= len;
            checksum <= '0;
            if (len == '0) begin
              state <= DONE;
            end else if (len > MAX_LEN) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          data_q   <= mem_rdata;
          checksum <= checksum + mem_rdata;
          src_ptr  <= src_ptr + AW'(1);
          state    <= WR;
        end
        WR: begin
          // Pointers wrap 63->0 naturally through the AW-bit adders.
          dst_ptr <= dst_ptr + AW'(1);
          cnt     <= cnt - (AW+1)'(1);
          state   <= (cnt != (AW+1)'(1)) ? RD : DONE;
        end
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RD) || (state == WR);
  assign done      = (state == DONE);
  assign MemRead   = (state == RD);
  // Gated by rst so an abort never lets a write land on the reset edge.
  assign MemWrite  = (state == WR) && !rst;
  assign mem_addr  = (state == RD) ? src_ptr : (state == WR) ? dst_ptr : '0;
  assign mem_wdata = (state == WR) ? data_q : '0;
  assign dbg_state = state;

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
- Bus initiator for the 64 x 32-bit data memory. Drives MemRead/MemWrite/address/write-data into the memory's slave port.
- Copies a block of words from a source region to a destination region: one read cycle, then one write cycle, per word.
- Accumulates a 32-bit checksum of the copied words.
- Sits beside the datapath as a memory-to-memory mover; test firmware uses it to relocate data blocks.

Parameters:
- AW, 6, memory word-address width (depth 2^AW = 64).
- DW, 32, data word width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  AW  first source word address.
- dst_addr  in  AW  first destination word address.
- len  in  AW+1  word count, 0..64.
- busy  out  1  high while a copy is in progress (RD or WR state).
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = len out of range, nothing copied.
- checksum  out  DW  modulo-2^DW sum of words copied; held until the next accepted start.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  DW  write data to memory.
- mem_rdata  in  DW  read data from memory (combinational while MemRead=1).

Behaviour:
- States: IDLE, RD, WR, DONE. Moore outputs decoded from registered state/pointers.
- Reset (rst high at an edge):
  - state=IDLE; busy=0, done=0, err=0, checksum=0; MemRead=0, mem_addr=0, mem_wdata=0.
  - MemWrite = (state==WR) & ~rst, so no memory write lands on the reset edge, even mid-copy.
- IDLE, start=1 at edge E0: latch src/dst pointers; remaining count cnt=len; clear checksum.
  - len==0 -> DONE, err=0.
  - len>64 -> DONE, err=1.
  - Otherwise -> RD.
- IDLE, start=0: stay in IDLE.
- RD: MemRead=1, mem_addr=src_ptr.
  - At the edge: capture mem_rdata into the data register, add it to checksum, src_ptr+1 (mod 64), -> WR.
- WR: MemWrite=1, mem_addr=dst_ptr, mem_wdata=data register.
  - At the edge: the memory commits the word; dst_ptr+1 (mod 64); cnt-1.
  - Then -> RD if cnt!=1, else -> DONE.
- DONE: done=1 for exactly one cycle, err held; -> IDLE. err returns to 0 in IDLE.
- Latency:
  - len=N (1..64): N reads at E0..E(2N-2) and N writes at E1..E(2N-1); done is high in the cycle after edge E(2N).
  - len=0 or err: done is high in the cycle after E0.
- Bus rules:
  - MemRead and MemWrite are never both 1.
  - Both are 0 in IDLE and DONE.
  - mem_addr=0 when idle.
- Address wrap: pointers wrap 63->0 silently.
- Overlap: copy is strictly ascending. If dst is in (src, src+len), words are overwritten before they are read (documented, not corrected).
- start while busy or in DONE: ignored, no effect on the copy in progress.
- rst mid-copy: abort at that edge; destination holds only the words already written; checksum cleared.

Test Plan:
- Preload mem[0..2]=17,9,25. start, src=0, dst=10, len=3 -> MemRead/MemWrite alternate for 6 cycles; mem[10..12]=17,9,25; checksum=51; done is a one-cycle pulse in the cycle after E6; err=0.
- Preload mem[62]=1, mem[63]=2, mem[0]=3, mem[1]=4. src=62, dst=20, len=4 -> mem[20..23]=1,2,3,4; checksum=10 (source pointer wraps 63->0).
- len=0 -> done in the cycle after E0; no MemRead/MemWrite assertion; checksum=0. Then len=65 -> done with err=1; memory unchanged.
- During the len=3 copy, pulse start with src=40, dst=50, len=5 at E2 -> ignored; only mem[10..12] change; a single done pulse.
- Copy src=0, dst=30, len=3; assert rst during the second WR cycle -> mem[30]=17 written; mem[31], mem[32] unchanged; MemWrite=0 during the rst cycle; busy=0 and checksum=0 after that edge.
